pwm_meas: RTL and testbench



---
 rtl/pwm_meas_pkg.sv | 16 +
 rtl/pwm_div_serial.sv | 74 +++++++
 rtl/pwm_meas.sv | 192 +++++++++++++++++++
 tb/tb_pwm_meas.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meas_pkg.sv
// Shared FSM encoding and default widths for the PWM measurement block.
// Widths here are defaults only; the top module re-exposes them as parameters.
package pwm_meas_pkg;

    localparam int DEF_CNT_W   = 10;
    localparam int DEF_DUTY_W  = 9;
    localparam int DEF_TIMEOUT = 1023;
    localparam int DEF_MCNT_W  = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/pwm_div_serial.sv
// Serial restoring divider: quotient of dividend/divisor, one bit per cycle.
// Latency: busy for DUTY_W cycles after start_i; done_o/quot_o valid in the last busy cycle.
// Backpressure: none; start_i is ignored while busy, the caller must check busy_o.
module pwm_div_serial #(
    parameter int DUTY_W = 9,
    parameter int CNT_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [CNT_W+DUTY_W-1:0] dividend_i,
    input  logic [CNT_W-1:0]        divisor_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DUTY_W-1:0]       quot_o
);

    localparam int SW = $clog2(DUTY_W + 1);

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DUTY_W-1:0] lo_q, lo_d;
    logic [DUTY_W-2:0] quot_q, quot_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [SW-1:0]     step_q, step_d;
    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    diff;
    logic              ge;

    // The upper dividend part is always below the divisor, so the
    // remainder never needs more than CNT_W bits between steps.
    always_comb begin
        trial  = {rem_q, lo_q[DUTY_W-1]};
        ge     = (trial >= {1'b0, div_q});
        diff   = trial - {1'b0, div_q};
        quot_o = {quot_q, ge};
        rem_d  = rem_q;
        lo_d   = lo_q;
        quot_d = quot_q;
        div_d  = div_q;
        step_d = step_q;
        if (step_q != '0) begin
            rem_d  = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
            lo_d   = {lo_q[DUTY_W-2:0], 1'b0};
            quot_d = quot_o[DUTY_W-2:0];
            step_d = step_q - SW'(1);
        end else if (start_i) begin
            rem_d  = dividend_i[CNT_W+DUTY_W-1:DUTY_W];
            lo_d   = dividend_i[DUTY_W-1:0];
            quot_d = '0;
            div_d  = divisor_i;
            step_d = SW'(DUTY_W);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            lo_q   <= '0;
            quot_q <= '0;
            div_q  <= '0;
            step_q <= '0;
        end else begin
            rem_q  <= rem_d;
            lo_q   <= lo_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            step_q <= step_d;
        end
    end

    assign busy_o = (step_q != '0);
    assign done_o = (step_q == SW'(1));

endmodule

// File: rtl/pwm_meas.sv
// PWM period/high-time/duty measurement with timeout, overrun flag and period count.
// Latency: results and valid_o appear DUTY_W+1 cycles after the closing rise is detected.
// Backpressure: none; a period closing while the divider is busy is dropped and sets overrun_o.
// Optional: define PWM_SYNC_EN to put a 2-flop synchronizer in front of the sample flop.
module pwm_meas
    import pwm_meas_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MCNT_W  = DEF_MCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  high_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              valid_o,
    output logic              timeout_o,
    output logic              stuck_lvl_o,
    output logic              overrun_o,
    output logic              busy_o,
    output logic [MCNT_W-1:0] meas_cnt_o
);

    logic pwm_src;

`ifdef PWM_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
        end
    end

    assign pwm_src = sync_q[1];
`else
    assign pwm_src = pwm_in;
`endif

    meas_state_e       state_q, state_d;
    logic              pwm_s_q, pwm_dly_q;
    logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
    logic [CNT_W-1:0]  lat_per_q, lat_per_d, lat_hi_q, lat_hi_d;
    logic [CNT_W-1:0]  period_q, period_d, high_q, high_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              stuck_q, stuck_d;
    logic              ovr_q, ovr_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              rise, fall, tmo;
    logic              div_start, div_busy, div_done, ovr_set;
    logic [DUTY_W-1:0] div_quot;

    assign rise = pwm_s_q & ~pwm_dly_q;
    assign fall = ~pwm_s_q & pwm_dly_q;
    assign tmo  = (state_q != ST_IDLE) && (per_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        lat_per_d = lat_per_q;
        lat_hi_d  = lat_hi_q;
        div_start = 1'b0;
        ovr_set   = 1'b0;
        timeout_d = 1'b0;
        stuck_d   = stuck_q;
        // Timeout wins over any edge seen in the same cycle.
        if (tmo) begin
            timeout_d = 1'b1;
            stuck_d   = pwm_s_q;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        per_d   = CNT_W'(1);
                        hi_d    = CNT_W'(1);
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    per_d = per_q + CNT_W'(1);
                    if (fall) begin
                        state_d = ST_LOW;
                    end else begin
                        hi_d = hi_q + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        if (div_busy) begin
                            ovr_set = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            lat_per_d = per_q;
                            lat_hi_d  = hi_q;
                        end
                        per_d   = CNT_W'(1);
                        hi_d    = CNT_W'(1);
                        state_d = ST_HIGH;
                    end else begin
                        per_d = per_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        valid_d  = div_done;
        period_d = div_done ? lat_per_q : period_q;
        high_d   = div_done ? lat_hi_q  : high_q;
        duty_d   = div_done ? div_quot  : duty_q;

        mcnt_d = mcnt_q;
        ovr_d  = ovr_q | ovr_set;
        if (clr_cnt) begin
            mcnt_d = '0;
            ovr_d  = 1'b0;
        end else if (valid_q) begin
            mcnt_d = mcnt_q + MCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pwm_s_q   <= 1'b0;
            pwm_dly_q <= 1'b0;
            per_q     <= '0;
            hi_q      <= '0;
            lat_per_q <= '0;
            lat_hi_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
            ovr_q     <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pwm_s_q   <= pwm_src;
            pwm_dly_q <= pwm_s_q;
            per_q     <= per_d;
            hi_q      <= hi_d;
            lat_per_q <= lat_per_d;
            lat_hi_q  <= lat_hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
            ovr_q     <= ovr_d;
            mcnt_q    <= mcnt_d;
        end
    end

    pwm_div_serial #(
        .DUTY_W (DUTY_W),
        .CNT_W  (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i ({hi_q, {DUTY_W{1'b0}}}),
        .divisor_i  (per_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    assign period_o    = period_q;
    assign high_o      = high_q;
    assign duty_o      = duty_q;
    assign valid_o     = valid_q;
    assign timeout_o   = timeout_q;
    assign stuck_lvl_o = stuck_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = div_busy;
    assign meas_cnt_o  = mcnt_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Bench for pwm_meas: waveforms are built as level arrays, an edge-level model derives
// the expected per-cycle strobes/counters, and each scenario adds fixed-value checks.
module tb_pwm_meas;

    localparam int CNT_W   = 10;
    localparam int DUTY_W  = 9;
    localparam int TIMEOUT = 1023;
    localparam int MCNT_W  = 14;
`ifdef PWM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int MAXN = 8192;

    logic              clk = 1'b0;
    logic              rst_n, pwm_in, clr_cnt;
    logic [CNT_W-1:0]  period_o, high_o;
    logic [DUTY_W-1:0] duty_o;
    logic              valid_o, timeout_o, stuck_lvl_o, overrun_o, busy_o;
    logic [MCNT_W-1:0] meas_cnt_o;

    pwm_meas #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT), .MCNT_W(MCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .clr_cnt(clr_cnt),
        .period_o(period_o), .high_o(high_o), .duty_o(duty_o), .valid_o(valid_o),
        .timeout_o(timeout_o), .stuck_lvl_o(stuck_lvl_o), .overrun_o(overrun_o),
        .busy_o(busy_o), .meas_cnt_o(meas_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit wave[MAXN+32];
    bit clrv[MAXN+32];
    int wlen;
    bit e_vld[MAXN+32], e_tmo[MAXN+32], e_stuck[MAXN+32], e_busy[MAXN+32];
    bit e_oset[MAXN+32], e_ovr[MAXN+32];
    int e_per[MAXN+32], e_hi[MAXN+32], e_duty[MAXN+32], e_mcnt[MAXN+32];

    int obs_per[$], obs_hi[$], obs_duty[$], obs_vcyc[$];
    int obs_tmo;
    bit obs_stuck, obs_ovr_seen, last_busy;

    task automatic clear_wave();
        wlen = 0;
        for (int i = 0; i < MAXN + 32; i++) begin
            wave[i] = 1'b0;
            clrv[i] = 1'b0;
        end
    endtask

    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (wlen < MAXN) begin
                wave[wlen] = v;
                wlen++;
            end
        end
    endtask

    task automatic add_pulse(input int hi, input int per);
        add_level(1'b1, hi);
        add_level(1'b0, per - hi);
    endtask

    // Level seen by the edge detector in DUT cycle t.
    function automatic bit lvl(input int t);
        if (t >= LAT && (t - LAT) < wlen) return wave[t - LAT];
        return 1'b0;
    endfunction

    task automatic model_events();
        int start, fall_t, last_acc, per, hi;
        bit active, r, f;
        for (int i = 0; i < MAXN + 32; i++) begin
            e_vld[i] = 0; e_tmo[i] = 0; e_stuck[i] = 0; e_busy[i] = 0; e_oset[i] = 0;
            e_per[i] = 0; e_hi[i] = 0; e_duty[i] = 0;
        end
        active = 0; start = 0; fall_t = 0; last_acc = -100;
        for (int t = 0; t < wlen; t++) begin
            r = lvl(t) && !lvl(t - 1);
            f = !lvl(t) && lvl(t - 1);
            if (active && (t - start) >= TIMEOUT) begin
                active = 0;
                e_tmo[t + 1] = 1;
                e_stuck[t + 1] = lvl(t);
            end else if (r) begin
                if (active) begin
                    per = t - start;
                    hi  = fall_t - start;
                    if (t > last_acc + DUTY_W) begin
                        last_acc = t;
                        for (int k = 1; k <= DUTY_W; k++) e_busy[t + k] = 1;
                        e_vld[t + DUTY_W + 1]  = 1;
                        e_per[t + DUTY_W + 1]  = per;
                        e_hi[t + DUTY_W + 1]   = hi;
                        e_duty[t + DUTY_W + 1] = (hi * (1 << DUTY_W)) / per;
                    end else begin
                        e_oset[t] = 1;
                    end
                end
                active = 1;
                start  = t;
            end else if (f && active) begin
                fall_t = t;
            end
        end
    endtask

    task automatic model_counters();
        e_mcnt[0] = 0;
        e_ovr[0]  = 0;
        for (int t = 0; t < wlen; t++) begin
            if (clrv[t]) begin
                e_mcnt[t + 1] = 0;
                e_ovr[t + 1]  = 0;
            end else begin
                e_mcnt[t + 1] = e_vld[t] ? ((e_mcnt[t] + 1) % (1 << MCNT_W)) : e_mcnt[t];
                e_ovr[t + 1]  = e_ovr[t] | e_oset[t];
            end
        end
    endtask

    // One-cycle reset, reset-state check, then the waveform with per-cycle checks.
    task automatic run_wave(input string name);
        model_events();
        model_counters();
        obs_per.delete(); obs_hi.delete(); obs_duty.delete(); obs_vcyc.delete();
        obs_tmo = 0; obs_stuck = 0; obs_ovr_seen = 0; last_busy = 0;
        rst_n = 1'b0; pwm_in = 1'b0; clr_cnt = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({period_o, high_o, duty_o, valid_o, timeout_o, stuck_lvl_o, overrun_o, busy_o, meas_cnt_o} !== '0) begin
            failures++;
            $display("FAIL %s reset_state got per=%0d hi=%0d duty=%0d vld=%0b tmo=%0b stk=%0b ovr=%0b busy=%0b cnt=%0d exp all 0",
                     name, period_o, high_o, duty_o, valid_o, timeout_o, stuck_lvl_o, overrun_o, busy_o, meas_cnt_o);
        end
        for (int t = 0; t < wlen; t++) begin
            checks++;
            if (valid_o !== e_vld[t]) begin
                failures++;
                $display("FAIL %s valid_o t=%0d got=%0b exp=%0b", name, t, valid_o, e_vld[t]);
            end
            if (e_vld[t]) begin
                checks++;
                if (period_o !== CNT_W'(e_per[t]) || high_o !== CNT_W'(e_hi[t]) || duty_o !== DUTY_W'(e_duty[t])) begin
                    failures++;
                    $display("FAIL %s result t=%0d got per=%0d hi=%0d duty=%0d exp per=%0d hi=%0d duty=%0d",
                             name, t, period_o, high_o, duty_o, e_per[t], e_hi[t], e_duty[t]);
                end
            end
            checks++;
            if (timeout_o !== e_tmo[t]) begin
                failures++;
                $display("FAIL %s timeout_o t=%0d got=%0b exp=%0b", name, t, timeout_o, e_tmo[t]);
            end
            if (e_tmo[t]) begin
                checks++;
                if (stuck_lvl_o !== e_stuck[t]) begin
                    failures++;
                    $display("FAIL %s stuck_lvl_o t=%0d got=%0b exp=%0b", name, t, stuck_lvl_o, e_stuck[t]);
                end
            end
            checks++;
            if (busy_o !== e_busy[t]) begin
                failures++;
                $display("FAIL %s busy_o t=%0d got=%0b exp=%0b", name, t, busy_o, e_busy[t]);
            end
            checks++;
            if (overrun_o !== e_ovr[t]) begin
                failures++;
                $display("FAIL %s overrun_o t=%0d got=%0b exp=%0b", name, t, overrun_o, e_ovr[t]);
            end
            checks++;
            if (meas_cnt_o !== MCNT_W'(e_mcnt[t])) begin
                failures++;
                $display("FAIL %s meas_cnt_o t=%0d got=%0d exp=%0d", name, t, meas_cnt_o, e_mcnt[t]);
            end
            if (valid_o === 1'b1) begin
                obs_per.push_back(int'(period_o));
                obs_hi.push_back(int'(high_o));
                obs_duty.push_back(int'(duty_o));
                obs_vcyc.push_back(t);
            end
            if (timeout_o === 1'b1) begin
                obs_tmo++;
                obs_stuck = stuck_lvl_o;
            end
            if (overrun_o === 1'b1) obs_ovr_seen = 1'b1;
            last_busy = busy_o;
            rst_n   = 1'b1;
            pwm_in  = wave[t];
            clr_cnt = clrv[t];
            @(posedge clk); #1;
        end
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        clear_wave();
        add_level(1'b0, 12);
        run_wave("reset");
    endtask

    task automatic test_basic();
        clear_wave();
        add_level(1'b0, 3);
        add_pulse(100, 334);
        add_pulse(100, 334);
        add_level(1'b1, 100);
        add_level(1'b0, 40);
        run_wave("basic");
        checks++;
        if (obs_per.size() != 2) begin
            failures++;
            $display("FAIL basic valid_count got=%0d exp=2", obs_per.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_per[i] != 334 || obs_hi[i] != 100 || obs_duty[i] != 153) begin
                    failures++;
                    $display("FAIL basic result%0d got per=%0d hi=%0d duty=%0d exp 334/100/153",
                             i, obs_per[i], obs_hi[i], obs_duty[i]);
                end
            end
            checks++;
            if (obs_vcyc[0] != 3 + 334 + LAT + 10) begin
                failures++;
                $display("FAIL basic valid_latency got t=%0d exp t=%0d", obs_vcyc[0], 3 + 334 + LAT + 10);
            end
        end
        checks++;
        if (meas_cnt_o !== MCNT_W'(2)) begin
            failures++;
            $display("FAIL basic meas_cnt got=%0d exp=2", meas_cnt_o);
        end
    endtask

    task automatic test_duty_edges();
        int exp_d[3];
        exp_d[0] = 256; exp_d[1] = 1; exp_d[2] = 510;
        clear_wave();
        add_level(1'b0, 3);
        add_pulse(167, 334);
        add_pulse(1, 334);
        add_pulse(333, 334);
        add_level(1'b1, 5);
        add_level(1'b0, 30);
        run_wave("duty_edges");
        checks++;
        if (obs_duty.size() != 3) begin
            failures++;
            $display("FAIL duty_edges valid_count got=%0d exp=3", obs_duty.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_duty[i] != exp_d[i] || obs_per[i] != 334) begin
                    failures++;
                    $display("FAIL duty_edges duty%0d got duty=%0d per=%0d exp duty=%0d per=334",
                             i, obs_duty[i], obs_per[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        clear_wave();
        add_level(1'b0, 3);
        add_level(1'b1, 1100);
        add_level(1'b0, 50);
        add_pulse(100, 334);
        add_level(1'b1, 20);
        add_level(1'b0, 30);
        run_wave("timeout");
        checks++;
        if (obs_tmo != 1 || obs_stuck !== 1'b1) begin
            failures++;
            $display("FAIL timeout pulse got count=%0d stuck=%0b exp count=1 stuck=1", obs_tmo, obs_stuck);
        end
        checks++;
        if (obs_per.size() != 1 || (obs_per.size() == 1 && (obs_per[0] != 334 || obs_hi[0] != 100))) begin
            failures++;
            $display("FAIL timeout recovery got valid_count=%0d exp one 334/100 result", obs_per.size());
        end
    endtask

    task automatic test_overrun();
        clear_wave();
        add_level(1'b0, 3);
        for (int i = 0; i < 10; i++) add_pulse(3, 6);
        add_level(1'b0, 40);
        clrv[wlen - 10] = 1'b1;
        run_wave("overrun");
        checks++;
        if (!obs_ovr_seen) begin
            failures++;
            $display("FAIL overrun seen got=0 exp=1");
        end
        checks++;
        if (obs_duty.size() != 5) begin
            failures++;
            $display("FAIL overrun accepted_count got=%0d exp=5", obs_duty.size());
        end
        checks++;
        if (overrun_o !== 1'b0 || meas_cnt_o !== '0) begin
            failures++;
            $display("FAIL overrun after_clr got ovr=%0b cnt=%0d exp ovr=0 cnt=0", overrun_o, meas_cnt_o);
        end
    endtask

    task automatic test_clr_on_valid();
        bit found;
        found = 0;
        clear_wave();
        add_level(1'b0, 3);
        add_pulse(100, 334);
        add_pulse(50, 334);
        add_level(1'b1, 5);
        add_level(1'b0, 30);
        model_events();
        for (int t = 0; t < wlen; t++) begin
            if (e_vld[t] && !found) begin
                clrv[t] = 1'b1;
                found = 1;
            end
        end
        run_wave("clr_on_valid");
        checks++;
        if (meas_cnt_o !== MCNT_W'(1)) begin
            failures++;
            $display("FAIL clr_on_valid final_cnt got=%0d exp=1", meas_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        clear_wave();
        add_level(1'b0, 3);
        add_pulse(100, 334);
        add_level(1'b1, 6);
        run_wave("reset_busy");
        checks++;
        if (last_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy precondition got busy=%0b exp=1", last_busy);
        end
        clear_wave();
        add_level(1'b0, 3);
        add_level(1'b1, 40);
        run_wave("reset_high");
        clear_wave();
        add_level(1'b0, 3);
        add_pulse(100, 334);
        add_level(1'b1, 5);
        add_level(1'b0, 20);
        run_wave("reset_recover");
        checks++;
        if (obs_per.size() != 1 || (obs_per.size() == 1 && (obs_per[0] != 334 || obs_hi[0] != 100))) begin
            failures++;
            $display("FAIL reset_recover got valid_count=%0d exp one 334/100 result", obs_per.size());
        end
    endtask

    task automatic test_random();
        int kind, per, hi;
        for (int r = 0; r < 3; r++) begin
            clear_wave();
            add_level(1'b0, 3);
            for (int p = 0; p < 6; p++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    add_level(1'b1, $urandom_range(1030, 1100));
                    add_level(1'b0, $urandom_range(5, 50));
                end else begin
                    per = (kind <= 2) ? $urandom_range(2, 12) : $urandom_range(20, 700);
                    hi  = $urandom_range(1, per - 1);
                    add_pulse(hi, per);
                end
            end
            add_level(1'b1, 5);
            add_level(1'b0, 20);
            for (int t = 0; t < wlen; t++) clrv[t] = ($urandom_range(0, 199) == 0);
            run_wave("random");
        end
    endtask

    initial begin
        rst_n = 1'b0; pwm_in = 1'b0; clr_cnt = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_duty_edges();
        test_timeout();
        test_overrun();
        test_clr_on_valid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
